// File: rtl/buffer_ram_stream_reader_if.sv
// Bundle of burst control, buffer RAM read port and output stream signals
// for buffer_ram_stream_reader.
interface buffer_ram_stream_reader_if #(
  parameter int DEPTHAD = 9,
  parameter int WIDTH   = 16
);
  logic               start;
  logic [DEPTHAD-1:0] base_addr;
  logic [DEPTHAD:0]   count;
  logic               busy;
  logic               done;
  logic [DEPTHAD-1:0] raddr;
  logic [WIDTH-1:0]   rdata;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic               out_ready;

  modport master (
    input  start, base_addr, count, rdata, out_ready,
    output busy, done, raddr, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, count, rdata, out_ready,
    input  busy, done, raddr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/buffer_ram_stream_reader.sv
// Burst read sequencer for a fixed-latency buffer RAM with a credit-limited output FIFO.
// Define BUFFER_READER_PERF_EN to add the stall_cycles backpressure counter.
module buffer_ram_stream_reader #(
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 2,
  parameter int WIDTH        = 16,
  parameter int DEPTHAD      = $clog2(DEPTH),
  parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
  input  logic clk,
  input  logic rst_n,
  buffer_ram_stream_reader_if.master bus
`ifdef BUFFER_READER_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = DEPTHAD + 1;
  localparam logic [CW-1:0]      FD_C      = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]      PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [DEPTHAD-1:0] LAST_ADDR = DEPTHAD'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_reg;
  logic [DEPTHAD-1:0] raddr_reg;
  logic [CNTW-1:0]    remaining_reg;
  logic [CW-1:0]      credit_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [READ_LATENCY-1:0] tag_reg, tag_next;
  logic [READ_LATENCY-1:0] tlast_reg, tlast_next;

  logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic             fifo_last [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    occ_reg;

  logic issue, issue_last, push, push_last, pop;

  // Credits cover every word from issue to pop, so the FIFO always has room
  // for whatever the non-stallable RAM pipeline delivers.
  assign issue      = (state_reg == RUN) && (credit_reg < FD_C);
  assign issue_last = issue && (remaining_reg == CNTW'(1));
  assign push       = tag_reg[READ_LATENCY-1];
  assign push_last  = tlast_reg[READ_LATENCY-1];
  assign pop        = (occ_reg != '0) && bus.out_ready;

  assign tag_next[0]   = issue;
  assign tlast_next[0] = issue_last;
  genvar gi;
  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
      assign tag_next[gi]   = tag_reg[gi-1];
      assign tlast_next[gi] = tlast_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_reg   <= '0;
      tlast_reg <= '0;
    end else begin
      tag_reg   <= tag_next;
      tlast_reg <= tlast_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      raddr_reg     <= '0;
      remaining_reg <= '0;
      credit_reg    <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      credit_reg <= credit_reg + CW'(issue) - CW'(pop);
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            raddr_reg     <= bus.base_addr;
            remaining_reg <= bus.count;
            busy_reg      <= 1'b1;
            state_reg     <= (bus.count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            raddr_reg     <= (raddr_reg == LAST_ADDR) ? '0 : raddr_reg + DEPTHAD'(1);
            remaining_reg <= remaining_reg - CNTW'(1);
            if (issue_last) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (credit_reg == '0) state_reg <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr_reg] <= bus.rdata;
        fifo_last[wr_ptr_reg] <= push_last;
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop) rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
      occ_reg <= occ_reg + CW'(push) - CW'(pop);
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && (occ_reg == FD_C)));

  assign bus.raddr     = raddr_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.out_valid = (occ_reg != '0);
  assign bus.out_data  = fifo_data[rd_ptr_reg];
  assign bus.out_last  = (occ_reg != '0) && fifo_last[rd_ptr_reg];

`ifdef BUFFER_READER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      stall_cycles <= '0;
    end else if (busy_reg && (occ_reg != '0) && !bus.out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_buffer_ram_stream_reader.sv
// Bench for buffer_ram_stream_reader: directed and random bursts checked
// against an address-sequence reference model of the expected stream.
`timescale 1ns/1ps
module tb_buffer_ram_stream_reader;
  localparam int DEPTH   = 512;
  localparam int L       = 2;
  localparam int WIDTH   = 16;
  localparam int DEPTHAD = 9;
  localparam int FD      = L + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buffer_ram_stream_reader_if #(.DEPTHAD(DEPTHAD), .WIDTH(WIDTH)) bus ();
`ifdef BUFFER_READER_PERF_EN
  logic [31:0] stall_cycles;
`endif

  buffer_ram_stream_reader #(
    .DEPTH(DEPTH), .READ_LATENCY(L), .WIDTH(WIDTH), .DEPTHAD(DEPTHAD), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef BUFFER_READER_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // Buffer RAM with fixed read latency L and no read enable
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rpipe [L];
  always @(posedge clk) begin
    rpipe[0] <= mem[bus.raddr];
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.rdata = rpipe[L-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_raddr"}, bus.raddr, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
  endtask

  // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready,
  //       3 ready low for the first 7 valid cycles
  task automatic run_burst(input int base, input int cnt, input int mode,
                           input bit second_start, input int abort_after);
    logic [WIDTH-1:0] exp_q[$];
    logic [DEPTHAD-1:0] prev;
    int beats = 0, cyc, issued = 0, done_cnt = 0, first_v = -1, last_b = -1;
    int stalls = 0, done_cyc = -1;
    bit finished = 0;
    for (int i = 0; i < cnt; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = DEPTHAD'(base);
    bus.count     = (DEPTHAD+1)'(cnt);
    @(negedge clk);
    cyc = 1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("raddr_first", bus.raddr, base);
    prev = bus.raddr;
    while (!finished) begin
      if (bus.raddr != prev) begin
        chk("raddr_step", bus.raddr, (prev + 1) % DEPTH);
        issued++;
        prev = bus.raddr;
      end
      case (mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        2: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          bus.out_ready = !(bus.out_valid && stalls < 7);
          if (bus.out_valid && !bus.out_ready) stalls++;
        end
      endcase
      chk("credit_bound", (issued - beats) <= FD, 1);
      if (bus.out_valid && first_v < 0) first_v = cyc;
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_within_count", beats < cnt, 1);
        if (exp_q.size() > 0) begin
          $display("beat %0d data=%h last=%b cyc=%0d", beats, bus.out_data, bus.out_last, cyc);
          chk("beat_data", bus.out_data, exp_q.pop_front());
          chk("beat_last", bus.out_last, beats == cnt - 1);
        end
        beats++;
        last_b = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1;
      if (abort_after > 0 && beats == abort_after) begin
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        return;
      end
      bus.start = second_start && (cyc == 5);
      if (bus.start) begin
        bus.base_addr = DEPTHAD'(base + 100);
        bus.count     = (DEPTHAD+1)'(3);
      end
      if (cyc > 3000) begin
        n_cmp++;
        n_bad++;
        $error("FAIL burst_timeout observed=%0d cycles required=done pulse", cyc);
        finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    $display("burst base=%0d count=%0d mode=%0d beats=%0d done_cyc=%0d", base, cnt, mode, beats, done_cyc);
    chk("beats_total", beats, cnt);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", bus.busy, 0);
    chk("valid_after_done", bus.out_valid, 0);
    if (mode == 0 && cnt > 0) begin
      chk("first_valid_latency", first_v, L + 2);
      chk("no_gaps", last_b - first_v, cnt - 1);
    end
    if (cnt == 0) begin
      chk("zero_done_latency", done_cyc, 2);
      chk("zero_no_valid", first_v < 0, 1);
    end
`ifdef BUFFER_READER_PERF_EN
    if (mode == 3) chk("stall_cycles", stall_cycles, 7);
`endif
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'(k + 100);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    run_burst(10, 8, 0, 1'b0, 0);
    run_burst(DEPTH - 3, 6, 0, 1'b0, 0);
    run_burst(37, 20, 1, 1'b0, 0);
    run_burst(200, 0, 0, 1'b0, 0);
    run_burst(50, 16, 0, 1'b1, 0);
    run_burst(300, 32, 0, 1'b0, 5);
    run_burst(0, 4, 0, 1'b0, 0);
`ifdef BUFFER_READER_PERF_EN
    run_burst(60, 4, 3, 1'b0, 0);
`endif

    for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'($urandom);
    for (int t = 0; t < 8; t++)
      run_burst($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), (t % 2 == 0) ? 2 : 0, 1'b0, 0);
    run_burst($urandom_range(0, DEPTH - 1), DEPTH, 2, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
